// File: rtl/dm_rom_arbiter.sv
// dm_rom_arbiter
//   Round-robin arbiter sharing one debug ROM read port between NumReq
//   requesters. The ROM registers its address and returns data one cycle
//   later, so every grant produces exactly one response the next cycle.
//   Addresses outside [BaseAddr, BaseAddr + 8*RomSize) never reach the ROM.
//   They are answered locally with an error response and zero data.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester read request, held with its address until granted
//   addr_i       per-requester byte address, slice i = addr_i[64*i +: 64]
//   gnt_o        one-hot grant, combinational from req_i and the RR pointer
//   rvalid_o     one-hot response valid, one cycle after the grant
//   rerr_o       response error (address outside window), qualified by |rvalid_o
//   rdata_o      shared response data, zero on error
//   rom_req_o    ROM request
//   rom_addr_o   ROM byte address (ROM decodes bits [7:3])
//   rom_rdata_i  ROM read data, valid the cycle after rom_req_o

module dm_rom_arbiter #(
  parameter int unsigned NumReq   = 2,
  parameter logic [63:0] BaseAddr = 64'h800,
  parameter int unsigned RomSize  = 19
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_i,
  input  logic [64*NumReq-1:0]   addr_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic [NumReq-1:0]      rvalid_o,
  output logic                   rerr_o,
  output logic [63:0]            rdata_o,
  output logic                   rom_req_o,
  output logic [63:0]            rom_addr_o,
  input  logic [63:0]            rom_rdata_i
);

  // A single requester still gets a 1-bit index so every vector stays legal.
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxW-1:0] rr_ptr_q;
  logic            resp_valid_q;
  logic [IdxW-1:0] resp_idx_q;
  logic            resp_err_q;

  logic            found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   scan_sum;
  logic [IdxW-1:0] scan_idx;
  logic [63:0]     win_addr;
  logic [63:0]     win_off;
  logic            in_win;

  // Scan from rr_ptr upwards with wrap. The first requester seen wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (scan_sum >= (IdxW+1)'(NumReq)) begin
        scan_sum = scan_sum - (IdxW+1)'(NumReq);
      end
      scan_idx = scan_sum[IdxW-1:0];
      if (!found && req_i[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i] = found && (win_idx == IdxW'(i));
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_addr = addr_i[64*i +: 64];
      end
    end
  end

  // The subtraction wraps for addresses below the base.
  // The explicit >= compare rejects those addresses.
  // Bits [2:0] select a byte inside a word and play no part in the check.
  assign win_off = win_addr - BaseAddr;
  assign in_win  = (win_addr >= BaseAddr) && (win_off[63:3] < 61'(RomSize));

  // The grant stays live during reset, but the ROM is not touched.
  assign rom_req_o  = rst_ni && found && in_win;
  assign rom_addr_o = rom_req_o ? win_addr : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= found;
      if (found) begin
        resp_idx_q <= win_idx;
        resp_err_q <= !in_win;
        if (win_idx == IdxW'(NumReq - 1)) begin
          rr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= win_idx + IdxW'(1);
        end
      end else begin
        resp_err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rvalid_o[i] = resp_valid_q && (resp_idx_q == IdxW'(i));
    end
  end

  assign rerr_o  = resp_valid_q && resp_err_q;
  assign rdata_o = (resp_valid_q && !resp_err_q) ? rom_rdata_i : '0;

endmodule

// File: tb/tb_dm_rom_arbiter.sv
module tb_dm_rom_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_i;
  logic [127:0] addr_i;
  logic [1:0]   gnt_o;
  logic [1:0]   rvalid_o;
  logic         rerr_o;
  logic [63:0]  rdata_o;
  logic         rom_req_o;
  logic [63:0]  rom_addr_o;
  logic [63:0]  rom_rdata_i = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  dm_rom_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rerr_o      (rerr_o),
    .rdata_o     (rdata_o),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i)
  );

  function automatic logic [63:0] word(input logic [4:0] w);
    return 64'hC0DE_0000_0000_0000 | {59'd0, w};
  endfunction

  // ROM model: the address is registered and the data appears the next cycle.
  always @(posedge clk_i) begin
    if (rom_req_o) rom_rdata_i <= word(rom_addr_o[7:3]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge. Checks run 1 time unit later.
  task automatic drive(input logic [1:0] r, input logic [63:0] a0, input logic [63:0] a1);
    @(negedge clk_i);
    req_i  = r;
    addr_i = {a1, a0};
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [1:0]  gnt;
    logic        rom_req;
    logic [63:0] rom_addr;
    logic [1:0]  rvalid;
    logic        rerr;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Response fields refer to the grant made by the previous vector.
    vecs[0]  = '{2'b01, 64'h800, 64'h0,   2'b01, 1'b1, 64'h800, 2'b00, 1'b0, 64'h0};
    vecs[1]  = '{2'b11, 64'h808, 64'h810, 2'b10, 1'b1, 64'h810, 2'b01, 1'b0, word(5'd0)};
    vecs[2]  = '{2'b11, 64'h808, 64'h810, 2'b01, 1'b1, 64'h808, 2'b10, 1'b0, word(5'd2)};
    vecs[3]  = '{2'b10, 64'h0,   64'h890, 2'b10, 1'b1, 64'h890, 2'b01, 1'b0, word(5'd1)};
    vecs[4]  = '{2'b01, 64'h898, 64'h0,   2'b01, 1'b0, 64'h0,   2'b10, 1'b0, word(5'd18)};
    vecs[5]  = '{2'b10, 64'h0,   64'h7F8, 2'b10, 1'b0, 64'h0,   2'b01, 1'b1, 64'h0};
    vecs[6]  = '{2'b01, 64'h897, 64'h0,   2'b01, 1'b1, 64'h897, 2'b10, 1'b1, 64'h0};
    vecs[7]  = '{2'b00, 64'h0,   64'h0,   2'b00, 1'b0, 64'h0,   2'b01, 1'b0, word(5'd18)};
    vecs[8]  = '{2'b11, 64'h800, 64'h808, 2'b10, 1'b1, 64'h808, 2'b00, 1'b0, 64'h0};
    vecs[9]  = '{2'b00, 64'h0,   64'h0,   2'b00, 1'b0, 64'h0,   2'b10, 1'b0, word(5'd1)};
    vecs[10] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'b01, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0};
    vecs[11] = '{2'b00, 64'h0,   64'h0,   2'b00, 1'b0, 64'h0,   2'b01, 1'b1, 64'h0};

    rst_ni = 1'b0;
    req_i  = 2'b01;
    addr_i = {64'h0, 64'h800};
    #12;
    chk("rst_gnt",     gnt_o, 2'b01);
    chk("rst_rom_req", rom_req_o, 1'b0);
    chk("rst_rvalid",  rvalid_o, 2'b00);
    chk("rst_rerr",    rerr_o, 1'b0);
    chk("rst_rdata",   rdata_o, 64'h0);
    @(negedge clk_i);
    req_i  = 2'b00;
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req, vecs[i].a0, vecs[i].a1);
      chk($sformatf("v%0d_gnt", i),      gnt_o,      vecs[i].gnt);
      chk($sformatf("v%0d_rom_req", i),  rom_req_o,  vecs[i].rom_req);
      chk($sformatf("v%0d_rom_addr", i), rom_addr_o, vecs[i].rom_addr);
      chk($sformatf("v%0d_rvalid", i),   rvalid_o,   vecs[i].rvalid);
      chk($sformatf("v%0d_rerr", i),     rerr_o,     vecs[i].rerr);
      chk($sformatf("v%0d_rdata", i),    rdata_o,    vecs[i].rdata);
    end

    // Back-to-back reads on requester 1 must return without bubbles.
    drive(2'b10, 64'h0, 64'h800);
    chk("b2b_gnt0", gnt_o, 2'b10);
    drive(2'b10, 64'h0, 64'h808);
    chk("b2b_rv0", rvalid_o, 2'b10);
    chk("b2b_d0",  rdata_o, word(5'd0));
    drive(2'b10, 64'h0, 64'h810);
    chk("b2b_rv1", rvalid_o, 2'b10);
    chk("b2b_d1",  rdata_o, word(5'd1));
    drive(2'b00, 64'h0, 64'h0);
    chk("b2b_rv2", rvalid_o, 2'b10);
    chk("b2b_d2",  rdata_o, word(5'd2));
    drive(2'b00, 64'h0, 64'h0);
    chk("b2b_idle", rvalid_o, 2'b00);

    // A reset during the response cycle drops the pending response.
    drive(2'b10, 64'h0, 64'h808);
    chk("mid_gnt", gnt_o, 2'b10);
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i  = 2'b00;
    #1;
    chk("mid_rvalid",  rvalid_o, 2'b00);
    chk("mid_rdata",   rdata_o, 64'h0);
    chk("mid_rom_req", rom_req_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i  = 2'b11;
    addr_i = {64'h808, 64'h800};
    #1;
    chk("post_rst_gnt", gnt_o, 2'b01);
    drive(2'b00, 64'h0, 64'h0);
    chk("post_rst_rv", rvalid_o, 2'b01);
    chk("post_rst_d",  rdata_o, word(5'd0));

    // The pointer holds through idle cycles.
    drive(2'b01, 64'h810, 64'h0);
    chk("hold_gnt0", gnt_o, 2'b01);
    for (int i = 0; i < 5; i++) drive(2'b00, 64'h0, 64'h0);
    drive(2'b11, 64'h800, 64'h808);
    chk("hold_gnt1", gnt_o, 2'b10);
    drive(2'b00, 64'h0, 64'h0);
    chk("hold_rv", rvalid_o, 2'b10);
    chk("hold_d",  rdata_o, word(5'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
